// File: rtl/calculator_pkg.sv
// Shared sizing constants and FSM state encoding for the calculator datapath controller.
package calculator_pkg;
    localparam int ADDR_W        = 10;
    localparam int DATA_W        = 32;
    localparam int MEM_WORD_SIZE = 64;

    typedef enum logic [3:0] {
        IDLE, RD_A, LD_A, RD_B, LD_B, SETTLE, WRITE, DONE, ERR
    } state_t;
endpackage

// File: rtl/calc_controller.sv
// Sequencer: reads operand word pairs from SRAM, feeds the external adder, steers sums
// into the result buffer halves and writes each filled buffer back, one word per 6 cycles.
module calc_controller
    import calculator_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [ADDR_W-1:0]        read_start_addr_i,
    input  logic [ADDR_W-1:0]        read_end_addr_i,
    input  logic [ADDR_W-1:0]        write_start_addr_i,
    input  logic [MEM_WORD_SIZE-1:0] mem_rdata_i,
    input  logic [MEM_WORD_SIZE-1:0] buffer_i,
    output logic                     mem_rd_en_o,
    output logic                     mem_wr_en_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [MEM_WORD_SIZE-1:0] mem_wdata_o,
    output logic [DATA_W-1:0]        operand_a_o,
    output logic [DATA_W-1:0]        operand_b_o,
    output logic                     loc_sel_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o
);
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   end_q, end_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic                loc_sel_q, loc_sel_d;
    logic [ADDR_W-1:0]   span;
    logic                range_bad;

    // An even span means an odd word count, which cannot form complete pairs.
    assign span      = read_end_addr_i - read_start_addr_i;
    assign range_bad = (read_start_addr_i > read_end_addr_i) || !span[0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            end_q     <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            loc_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            end_q     <= end_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            loc_sel_q <= loc_sel_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        end_d       = end_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        loc_sel_d   = loc_sel_q;
        mem_rd_en_o = 1'b0;
        mem_wr_en_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        done_o      = 1'b0;
        error_o     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    rd_ptr_d = read_start_addr_i;
                    wr_ptr_d = write_start_addr_i;
                    end_d    = read_end_addr_i;
                    state_d  = range_bad ? ERR : RD_A;
                end
            end
            RD_A: begin
                mem_rd_en_o = 1'b1;
                mem_addr_o  = rd_ptr_q;
                state_d     = LD_A;
            end
            LD_A: begin
                // Operands and half-select must move together: the buffer captures every clock.
                op_a_d    = mem_rdata_i[DATA_W-1:0];
                op_b_d    = mem_rdata_i[MEM_WORD_SIZE-1:DATA_W];
                loc_sel_d = 1'b0;
                rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
                state_d   = RD_B;
            end
            RD_B: begin
                mem_rd_en_o = 1'b1;
                mem_addr_o  = rd_ptr_q;
                state_d     = LD_B;
            end
            LD_B: begin
                op_a_d    = mem_rdata_i[DATA_W-1:0];
                op_b_d    = mem_rdata_i[MEM_WORD_SIZE-1:DATA_W];
                loc_sel_d = 1'b1;
                state_d   = SETTLE;
            end
            SETTLE: state_d = WRITE;
            WRITE: begin
                mem_wr_en_o = 1'b1;
                mem_addr_o  = wr_ptr_q;
                mem_wdata_o = buffer_i;
                wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
                // Compare before incrementing so an end address at the top of memory still stops.
                if (rd_ptr_q == end_q) begin
                    state_d = DONE;
                end else begin
                    rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                    state_d  = RD_A;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                error_o = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign operand_a_o = op_a_q;
    assign operand_b_o = op_b_q;
    assign loc_sel_o   = loc_sel_q;
    assign busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_calc_controller.sv
// Scoreboard bench for calc_controller: models the SRAM and the adder/result buffer,
// queues expected writes at stimulus time and compares them as the DUT issues them.
`timescale 1ns/1ps
module tb_calc_controller;
    import calculator_pkg::*;

    typedef struct {
        logic [ADDR_W-1:0]        addr;
        logic [MEM_WORD_SIZE-1:0] data;
    } wr_t;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     start = 1'b0;
    logic [ADDR_W-1:0]        rs = '0, re = '0, ws = '0;
    logic [MEM_WORD_SIZE-1:0] rdata_q = '0;
    logic [MEM_WORD_SIZE-1:0] buf_q = '0;
    logic                     rd_en, wr_en, loc_sel, busy, done_o, error_o;
    logic [ADDR_W-1:0]        addr;
    logic [MEM_WORD_SIZE-1:0] wdata;
    logic [DATA_W-1:0]        op_a, op_b;

    logic                     pl_en = 1'b0;
    logic [ADDR_W-1:0]        pl_addr = '0;
    logic [MEM_WORD_SIZE-1:0] pl_data = '0;
    logic [MEM_WORD_SIZE-1:0] mem [0:(1<<ADDR_W)-1];

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  rd_cnt = 0;
    int  wr_cnt = 0;

    always #5 clk = ~clk;

    calc_controller dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .start_i            (start),
        .read_start_addr_i  (rs),
        .read_end_addr_i    (re),
        .write_start_addr_i (ws),
        .mem_rdata_i        (rdata_q),
        .buffer_i           (buf_q),
        .mem_rd_en_o        (rd_en),
        .mem_wr_en_o        (wr_en),
        .mem_addr_o         (addr),
        .mem_wdata_o        (wdata),
        .operand_a_o        (op_a),
        .operand_b_o        (op_b),
        .loc_sel_o          (loc_sel),
        .busy_o             (busy),
        .done_o             (done_o),
        .error_o            (error_o)
    );

    // SRAM with one-cycle read latency, plus the adder feeding the result buffer every clock.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (wr_en) mem[addr] <= wdata;
        if (rd_en) rdata_q <= mem[addr];
        if (loc_sel) buf_q[63:32] <= op_a + op_b;
        else         buf_q[31:0]  <= op_a + op_b;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected write per write strobe.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rd_en) rd_cnt++;
                chk("strobe_excl", 64'(rd_en & wr_en), 64'd0);
                if (wr_en) begin
                    wr_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: addr %0d data %0h, none expected", addr, wdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", 64'(addr), 64'(e.addr));
                        chk("wr_data", wdata, e.data);
                    end
                end else begin
                    chk("wdata_idle", wdata, 64'd0);
                end
            end
        end
    end

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [63:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [63:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic run(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e,
                       input logic [ADDR_W-1:0] w, input bit bad, input int words,
                       input int mid_cyc, input string name);
        int cyc;
        int first_wr;
        bit got;
        @(negedge clk);
        rd_cnt = 0; wr_cnt = 0;
        rs = s; re = e; ws = w; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (bad) begin
            chk({name, "_err_pulse"}, 64'(error_o), 64'd1);
            chk({name, "_err_busy"}, 64'(busy), 64'd1);
            chk({name, "_err_nostrobe"}, 64'(rd_en | wr_en), 64'd0);
            @(negedge clk);
            chk({name, "_err_low"}, 64'(error_o), 64'd0);
            chk({name, "_err_idle"}, 64'(busy), 64'd0);
            chk({name, "_err_access"}, 64'(rd_cnt + wr_cnt), 64'd0);
        end else begin
            cyc = 1; got = 1'b0; first_wr = 0;
            while (!got && cyc < 6*words + 20) begin
                if (wr_en && first_wr == 0) first_wr = cyc;
                if (done_o) got = 1'b1;
                else begin
                    if (cyc == mid_cyc) begin
                        start = 1'b1; rs = '0; re = 10'd1; ws = 10'd60;
                    end
                    @(negedge clk);
                    start = 1'b0;
                    cyc++;
                end
            end
            chk({name, "_done_seen"}, 64'(got), 64'd1);
            chk({name, "_done_cycle"}, 64'(cyc), 64'(6*words + 1));
            chk({name, "_first_wr_cycle"}, 64'(first_wr), 64'd6);
            chk({name, "_reads"}, 64'(rd_cnt), 64'(2*words));
            chk({name, "_writes"}, 64'(wr_cnt), 64'(words));
            @(negedge clk);
            chk({name, "_done_low"}, 64'(done_o), 64'd0);
            chk({name, "_idle"}, 64'(busy), 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        #1;
        chk("rst_outputs", {52'd0, rd_en, wr_en, loc_sel, busy, done_o, error_o, 6'd0}, 64'd0);
        chk("rst_addr_wdata", 64'(addr) | wdata, 64'd0);
        chk("rst_operands", {op_b, op_a}, 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        preload(10'd0, 64'h00000002_00000001);
        preload(10'd1, 64'h00000005_00000004);
        expect_wr(10'd8, {32'd9, 32'd3});
        run(10'd0, 10'd1, 10'd8, 1'b0, 1, 0, "basic");
        chk("hold_operands", {op_b, op_a}, {32'd5, 32'd4});
        chk("hold_loc_sel", 64'(loc_sel), 64'd1);

        preload(10'd0, 64'h00000001_00000001);
        preload(10'd1, 64'h00000002_00000002);
        preload(10'd2, 64'h00000003_00000003);
        preload(10'd3, 64'h00000004_00000004);
        expect_wr(10'd16, {32'd4, 32'd2});
        expect_wr(10'd17, {32'd8, 32'd6});
        run(10'd0, 10'd3, 10'd16, 1'b0, 2, 0, "multi");

        run(10'd5, 10'd2, 10'd0, 1'b1, 0, 0, "reversed");
        run(10'd0, 10'd2, 10'd0, 1'b1, 0, 0, "odd_count");

        // Top-of-memory range; the first sum overflows and drops its carry.
        preload(10'd1022, 64'hFFFFFFFF_00000001);
        preload(10'd1023, 64'h0000000A_00000014);
        expect_wr(10'd1023, {32'd30, 32'd0});
        run(10'd1022, 10'd1023, 10'd1023, 1'b0, 1, 0, "top_end");

        expect_wr(10'd1023, {32'd4, 32'd2});
        expect_wr(10'd0, {32'd8, 32'd6});
        run(10'd0, 10'd3, 10'd1023, 1'b0, 2, 0, "wr_wrap");

        preload(10'd4, 64'h00000007_00000003);
        preload(10'd5, 64'h00000064_000000C8);
        @(negedge clk);
        rs = 10'd4; re = 10'd5; ws = 10'd40; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #2;
            if (wr_en) got = 1'b1;
        end
        chk("rst_reached_write", 64'(got), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {52'd0, rd_en, wr_en, loc_sel, busy, done_o, error_o, 6'd0}, 64'd0);
        chk("midrst_addr_wdata", 64'(addr) | wdata, 64'd0);
        chk("midrst_operands", {op_b, op_a}, 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        expect_wr(10'd40, {32'd300, 32'd10});
        run(10'd4, 10'd5, 10'd40, 1'b0, 1, 0, "post_rst");

        expect_wr(10'd50, {32'd300, 32'd10});
        run(10'd4, 10'd5, 10'd50, 1'b0, 1, 3, "busy_start");

        repeat (10) @(negedge clk);
        chk("no_extra_activity", 64'(busy | rd_en | wr_en), 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
